// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the tile UART transmitter.
package tt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/tt_uart_tx_baud.sv
// Bit-period timer: tick pulses for one cycle at the end of each serial bit.
module tt_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero while cleared so the first START cycle counts as 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/tt_uart_tx.sv
// 8N1/8N2 UART transmitter: accepts one byte on valid/ready, shifts it out LSB first.
module tt_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       tx_oe,
  output logic       busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("tt_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("tt_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 tx_oe_q;
  logic                 tick;
  logic                 hs;

  assign in_ready = (state_q == IDLE) && !rst;
  assign hs       = in_valid && in_ready;

  tt_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  // tx_d is the line level for the cycle after this edge, so tx is glitch-free.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          shift_d = in_data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            state_d   = STOP;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        // bit_cnt is reused here to count stop bits.
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) state_d = IDLE;
          else                        bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      tx_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      tx_oe_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx    = tx_q;
  assign tx_oe = tx_oe_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_tt_uart_tx.sv
// Directed bench for tt_uart_tx: one instance with one stop bit, one with two.
module tb_tt_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b, tx_oe_a, tx_oe_b, busy_a, busy_b;
  logic       sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tt_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx(tx_a), .tx_oe(tx_oe_a), .busy(busy_a)
  );

  tt_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .tx(tx_b), .tx_oe(tx_oe_b), .busy(busy_b)
  );

  wire obs_tx    = sel ? tx_b       : tx_a;
  wire obs_rdy   = sel ? in_ready_b : in_ready_a;
  wire obs_busy  = sel ? busy_b     : busy_a;
  wire obs_oe    = sel ? tx_oe_b    : tx_oe_a;
  wire obs_valid = sel ? in_valid_b : in_valid_a;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) in_valid_b = v;
    else     in_valid_a = v;
  endtask

  // Line level i cycles after the handshake edge for a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic logic [127:0] exp_tx(input logic [7:0] b, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = frame_bit(b, i);
    return v;
  endfunction

  function automatic logic [127:0] exp_rdy(input int stop, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = (i >= (9 + stop) * CPB);
    return v;
  endfunction

  // Caller has just made a handshake edge; sample n cycles starting now.
  task automatic capture(input int n, input int drop_at, input bit scramble,
                         input logic [7:0] data_after,
                         output logic [127:0] txv, output logic [127:0] rdyv,
                         output logic [127:0] bsyv, output int hs);
    txv = '0; rdyv = '0; bsyv = '0; hs = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      txv[i]  = obs_tx;
      rdyv[i] = obs_rdy;
      bsyv[i] = obs_busy;
      if (obs_valid && obs_rdy) hs++;
      if (i == drop_at) set_valid(1'b0);
      if (scramble)     in_data = 8'($urandom);
      else if (i == 0)  in_data = data_after;
    end
  endtask

  task automatic start(input logic [7:0] b);
    in_data = b;
    set_valid(1'b1);
    @(negedge clk);
  endtask

  logic [127:0] txv, rdyv, bsyv, etx, erdy;
  int hs;

  initial begin
    sel = 1'b0; rst = 1'b1; in_data = 8'h00; in_valid_a = 1'b0; in_valid_b = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 128'(obs_tx), 128'(1'b1));
    chk("rst_oe", 128'(obs_oe), 128'(1'b0));
    chk("rst_ready", 128'(obs_rdy), 128'(1'b0));
    chk("rst_busy", 128'(obs_busy), 128'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 128'(obs_rdy), 128'(1'b1));
    chk("rel_oe", 128'(obs_oe), 128'(1'b1));

    // Single byte 0xA5
    start(8'hA5);
    capture(41, 0, 1'b0, 8'hA5, txv, rdyv, bsyv, hs);
    chk("a5_tx", txv, exp_tx(8'hA5, 41));
    chk("a5_ready", rdyv, exp_rdy(1, 41));
    chk("a5_busy", bsyv, ~exp_rdy(1, 41) & exp_rdy(0, 0) | (~exp_rdy(1, 41) & ((128'd1 << 41) - 1)));

    // Back-to-back 0x00 then 0xFF with valid held high
    start(8'h00);
    capture(82, 41, 1'b0, 8'hFF, txv, rdyv, bsyv, hs);
    etx = '0; erdy = '0;
    for (int i = 0; i < 82; i++) begin
      etx[i]  = (i <= 40) ? frame_bit(8'h00, i) : frame_bit(8'hFF, i - 41);
      erdy[i] = (i == 40) || (i == 81);
    end
    chk("b2b_tx", txv, etx);
    chk("b2b_ready", rdyv, erdy);
    chk("b2b_handshakes", 128'(hs + 1), 128'd2);

    // Two stop bits, 0x3C: 44-cycle frame
    sel = 1'b1;
    start(8'h3C);
    capture(45, 0, 1'b0, 8'h3C, txv, rdyv, bsyv, hs);
    chk("stop2_tx", txv, exp_tx(8'h3C, 45));
    chk("stop2_ready", rdyv, exp_rdy(2, 45));
    chk("stop2_busy", bsyv, ~exp_rdy(2, 45) & ((128'd1 << 45) - 1));
    sel = 1'b0;

    // Reset on cycle 15 of a 0x55 frame, then a clean 0x81 frame
    start(8'h55);
    capture(15, 0, 1'b0, 8'h55, txv, rdyv, bsyv, hs);
    chk("pre_rst_tx", txv, exp_tx(8'h55, 15));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 128'(obs_tx), 128'(1'b1));
    chk("midrst_busy", 128'(obs_busy), 128'(1'b0));
    chk("midrst_ready", 128'(obs_rdy), 128'(1'b0));
    chk("midrst_oe", 128'(obs_oe), 128'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", 128'(obs_rdy), 128'(1'b1));
    start(8'h81);
    capture(41, 0, 1'b0, 8'h81, txv, rdyv, bsyv, hs);
    chk("x81_tx", txv, exp_tx(8'h81, 41));
    chk("x81_ready", rdyv, exp_rdy(1, 41));

    // 0xC3 with in_data scrambled and in_valid dropped mid-frame
    start(8'hC3);
    capture(41, 0, 1'b1, 8'h00, txv, rdyv, bsyv, hs);
    chk("c3_tx", txv, exp_tx(8'hC3, 41));
    chk("c3_ready", rdyv, exp_rdy(1, 41));
    chk("c3_handshakes", 128'(hs), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_uart_tx.md
Name: tt_uart_tx

Overview:
- Byte-serialising UART transmitter for the tile's output pins.
- Outbound counterpart of the tile's parallel pin-input path: it takes bytes from on-tile logic over a valid/ready handshake and drives them as 8N1 (optionally 8N2) frames on one uio pin.
- Instantiated inside the tile top. tx goes to uio_out[0] and tx_oe goes to uio_oe[0].

Parameters:
- CLKS_PER_BIT, default 104: clock cycles per serial bit. Must be ≥ 2. 104 gives 115200 baud at 12 MHz.
- STOP_BITS, default 1: number of stop bits. Legal values are 1 and 2.

Ports:
- clk  input  1  tile clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  8  byte to transmit; sampled only on handshake
- in_valid  input  1  producer has a byte
- in_ready  output  1  transmitter can accept a byte this cycle
- tx  output  1  serial line; idle high
- tx_oe  output  1  pad output enable for the tx pin
- busy  output  1  high while a frame is in progress

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values (registered outputs, valid from the first edge with rst=1):
  - tx=1, tx_oe=0, busy=0, state=IDLE, bit counter=0, baud counter=0.
  - in_ready=0 while rst=1.
- tx_oe=1 from the first cycle after rst deasserts, and stays 1 until the next reset.
- in_ready=1 exactly when state==IDLE and rst=0.
- Handshake fires when in_valid & in_ready. in_data is latched into an 8-bit shift register on that edge. No buffering beyond this one register.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on handshake.
  - START: tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After 8 bits -> STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then -> IDLE.
- Latency: tx falls on the edge after the handshake edge (registered output).
- A full frame is (10 or 11)*CLKS_PER_BIT cycles from the tx falling edge to in_ready rising again.
- Back-to-back transfers:
  - in_ready returns on the first cycle of IDLE.
  - If in_valid is already high, a new START begins one cycle later.
  - Minimum inter-frame idle is therefore exactly 1 clk.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Cleared on entry to START.
  - The bit advances when counter == CLKS_PER_BIT-1.
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- in_data changes while not in a handshake cycle are ignored. An in_valid drop mid-frame has no effect.
- Reset mid-frame: on the next edge, state is forced to IDLE and tx=1. The frame is truncated and not resumed. The shift register content is discarded.
- rst together with in_valid in the same cycle: no handshake, because in_ready=0.
- Elaboration error if CLKS_PER_BIT < 2 or STOP_BITS is not in {1,2}.

Decomposition:
- Package tt_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP), 2-bit encoding;
  - DATA_BITS=8;
  - bit-counter width 3.
- One sub-module, tt_baud_gen:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst, clear;
  - output tick, a 1-cycle pulse at the end of each bit period.
- The FSM, shift register and bit counter stay in tt_uart_tx.

Test Plan (all scenarios use CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- Reset: rst=1 for 3 cycles -> tx=1, tx_oe=0, in_ready=0, busy=0. After release -> in_ready=1, tx_oe=1.
- Single byte 0xA5, in_valid held 1 cycle:
  - tx reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each exactly 4 cycles;
  - in_ready=0 for 40 cycles, then 1.
- Back-to-back 0x00 then 0xFF with in_valid held high:
  - second start bit begins exactly 1 cycle after the first frame's stop ends;
  - exactly two handshakes occur.
- STOP_BITS=2, byte 0x3C -> stop high for 8 cycles; frame length is 44 cycles.
- Reset asserted on cycle 15 of a 0x55 frame:
  - next edge gives tx=1, busy=0;
  - after release a new 0x81 frame is transmitted correctly from its start bit.
- in_data toggled randomly and in_valid dropped mid-frame after accepting 0xC3 -> the serial output still equals 0xC3, LSB first.
